// File: rtl/rv32i_types.sv
// Shared RV32I datapath types for the load/store unit: FSM state encoding,
// load/store funct3 codes and the funct3 legality helper.
package rv32i_types;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ACC0 = 2'd1,
        LSU_ACC1 = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Doubleword and lwu only exist on a 64-bit datapath; stores never zero-extend.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3,
                                      input logic dw64);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ok = 1'b1;
                F3_SD:               ok = dw64;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
                F3_LD, F3_LWU:                       ok = dw64;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the right-justified load assembly value from
// 8 << size_i bits up to the full datapath width.
module lsu_extend #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] asm_i,
    input  logic [1:0]            size_i,
    input  logic                  unsigned_i,
    output logic [DATA_WIDTH-1:0] ext_o
);

    logic sign_s;
    int   nbits_s;

    // Keep the low nbits, fill the rest with the sign bit or zero
    always_comb begin
        nbits_s = int'(32'd8 << size_i);
        case (size_i)
            2'd0:    sign_s = asm_i[7];
            2'd1:    sign_s = asm_i[15];
            2'd2:    sign_s = asm_i[31];
            default: sign_s = asm_i[DATA_WIDTH-1];
        endcase
        ext_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < nbits_s) begin
                ext_o[i] = asm_i[i];
            end else begin
                ext_o[i] = sign_s & ~unsigned_i;
            end
        end
    end

endmodule

// File: rtl/lsu_align_fsm.sv
// Multicycle load/store unit: aligns addresses, generates lane enables and
// shifted store data, assembles and extends load data.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: split word-crossing accesses
// into two memory transactions; when undefined they complete with access_err.
module lsu_align_fsm
    import rv32i_types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    is_store,
    input  logic [2:0]              funct3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   load_data,
    output logic                    access_err,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LW = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;

    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d, wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic                  read_q, read_d, write_q, write_d;
    logic [NB-1:0]         be_q, be_d;

    logic [LW-1:0]         lane_s;
    logic [3:0]            size_s;
    logic [4:0]            end_s;
    logic                  mis_s, err_s, split_s;
    logic [15:0]           en_full_s, en_hi_s;
    logic [LW+2:0]         sh0_s;
    logic [LW:0]           n0_s;
    logic [LW+3:0]         sh1_s;
    logic [ADDR_WIDTH-1:0] aligned_s;
    logic [DATA_WIDTH-1:0] ext_s;

    // Capture the request when it is accepted in IDLE, otherwise hold it
    always_comb begin
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        store_data_d = store_data_q;
        if ((state_q == LSU_IDLE) && start) begin
            is_store_d   = is_store;
            funct3_d     = funct3;
            addr_d       = addr;
            store_data_d = store_data;
        end else begin
            is_store_d   = is_store_q;
        end
    end

    // Lane, size, misalignment and shift amounts of the latched request
    always_comb begin
        lane_s    = addr_d[LW-1:0];
        size_s    = 4'd1 << funct3_d[1:0];
        end_s     = 5'(lane_s) + 5'(size_s);
        mis_s     = end_s > 5'(NB);
        err_s     = ~f3_legal(is_store_d, funct3_d, DATA_WIDTH == 64) | (mis_s & ~SPLIT_EN);
        split_s   = mis_s & SPLIT_EN;
        en_full_s = ((16'd1 << size_s) - 16'd1) << lane_s;
        en_hi_s   = en_full_s >> NB;
        sh0_s     = {lane_s, 3'b000};
        n0_s      = (LW+1)'(NB) - {1'b0, lane_s};
        sh1_s     = {n0_s, 3'b000};
        aligned_s = {addr_d[ADDR_WIDTH-1:LW], {LW{1'b0}}};
    end

    lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
        .asm_i      (asm_d),
        .size_i     (funct3_d[1:0]),
        .unsigned_i (funct3_d[2]),
        .ext_o      (ext_s)
    );

    // Next state and load byte assembly
    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    state_d = err_s ? LSU_DONE : LSU_ACC0;
                end else begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_ACC0: begin
                if (mem_resp) begin
                    asm_d   = mem_rdata >> sh0_s;
                    state_d = split_s ? LSU_ACC1 : LSU_DONE;
                end else begin
                    state_d = LSU_ACC0;
                end
            end
            LSU_ACC1: begin
                if (mem_resp) begin
                    asm_d   = asm_q | (mem_rdata << sh1_s);
                    state_d = LSU_DONE;
                end else begin
                    state_d = LSU_ACC1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from next state and request
    always_comb begin
        busy_d  = state_d != LSU_IDLE;
        done_d  = state_d == LSU_DONE;
        err_d   = (state_d == LSU_DONE) & err_s;
        maddr_d = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
        be_d    = '0;
        wdata_d = '0;
        case (state_d)
            LSU_ACC0: begin
                maddr_d = aligned_s;
                read_d  = ~is_store_d;
                write_d = is_store_d;
                be_d    = en_full_s[NB-1:0];
                wdata_d = store_data_d << sh0_s;
            end
            LSU_ACC1: begin
                maddr_d = aligned_s + ADDR_WIDTH'(NB);
                read_d  = ~is_store_d;
                write_d = is_store_d;
                be_d    = en_hi_s[NB-1:0];
                wdata_d = store_data_d >> sh1_s;
            end
            default: begin
                maddr_d = '0;
            end
        endcase
        if ((state_q != LSU_DONE) && (state_d == LSU_DONE) && ~is_store_d && ~err_s) begin
            load_data_d = ext_s;
        end else begin
            load_data_d = load_data_q;
        end
    end

    // State, request and registered-output flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            store_data_q <= '0;
            asm_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            load_data_q  <= '0;
            maddr_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            store_data_q <= store_data_d;
            asm_q        <= asm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            load_data_q  <= load_data_d;
            maddr_q      <= maddr_d;
            read_q       <= read_d;
            write_q      <= write_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign access_err      = err_q;
    assign load_data       = load_data_q;
    assign mem_address     = maddr_q;
    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;

endmodule
